uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial transmitter: accepts a parallel byte over a valid/ready handshake and shifts it out LSB-first on a single line.
- Frame: start bit, data bits, stop bit.
- Transmit-side counterpart to the team's serial receive/sampling logic.
- Sits between a byte producer (test sequencer or FSM) and the physical tx pin.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be ≥2.
- DATA_BITS, 8, data bits per frame; range 5–9.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- tx_data  input  DATA_BITS  byte to send; sampled only at acceptance.
- tx_valid  input  1  producer has data.
- tx_ready  output  1  block can accept; high only in IDLE.
- tx  output  1  serial line, idle-high, registered.
- busy  output  1  high from the cycle after acceptance until return to IDLE.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, tx=1, tx_ready=1, busy=0.
  - Bit counter and baud counter cleared; shift register cleared.
- States: IDLE, START, DATA, STOP (plus PARITY when the macro is defined).
- Acceptance: tx_valid && tx_ready at a rising edge.
  - tx_data is latched into the shift register.
  - Baud counter zeroed; state goes to START.
  - tx_valid/tx_data are ignored at all other times.
- Latency: tx goes low on the edge of acceptance, i.e. visible in the first cycle after it.
- Baud counter counts 0..CLKS_PER_BIT-1. A bit ends when the count reaches CLKS_PER_BIT-1; each bit lasts exactly CLKS_PER_BIT cycles.
- START: tx=0 for one bit time, then DATA.
- DATA:
  - tx = shift register bit 0.
  - At each bit end: shift right, increment bit counter.
  - After DATA_BITS bits: go to STOP (or PARITY).
- STOP: tx=1 for one bit time, then IDLE.
- Frame length: (DATA_BITS+2)*CLKS_PER_BIT cycles.
- IDLE: tx=1, tx_ready=1, busy=0.
  - The earliest next acceptance is the first IDLE cycle.
  - Minimum line-idle gap between frames is therefore 1 cycle beyond the stop bit.
- tx_valid held high continuously: back-to-back frames with that 1-cycle gap; no frame dropped or duplicated.
- tx_valid deasserted mid-frame: no effect; the frame completes.
- Reset asserted mid-frame:
  - Frame aborted; tx=1 immediately.
  - The receiver sees a truncated frame; no recovery attempted.
- Counter widths: $clog2(CLKS_PER_BIT) for the baud counter, $clog2(DATA_BITS+1) for the bit counter.
- No counter wraps past its terminal value.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - tx = even parity, i.e. XOR of the latched data, for one bit time.
  - Parity is computed at acceptance from tx_data and held in a register.
  - Frame = (DATA_BITS+3)*CLKS_PER_BIT cycles.
- Undefined:
  - No PARITY state, no parity register.
  - Frame as in Behaviour.

Decomposition:
- Shared package uart_pkg:
  - State encoding constants: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; 3-bit state width.
  - Default CLKS_PER_BIT and DATA_BITS values.
  - Line-level constants: LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
  - The future receiver shares this package.
- One sub-module: uart_baud_tick.
  - Parameter CLKS_PER_BIT; inputs clk, reset, clear.
  - Output tick: one-cycle pulse at count CLKS_PER_BIT-1.
  - clear is driven by acceptance.

Test Plan (CLKS_PER_BIT=4, DATA_BITS=8 unless noted):
- Reset held 3 cycles, tx_valid=0 → tx=1, tx_ready=1, busy=0 throughout.
- Send tx_data=8'hA5 →
  - tx low cycles 1–4 after acceptance.
  - Then bits 1,0,1,0,0,1,0,1, each 4 cycles.
  - Then high 4 cycles; tx_ready returns at cycle 41; 40-cycle frame.
- tx_valid held high with data 8'h00 then 8'hFF →
  - Two complete frames.
  - Second start bit begins exactly 1 cycle after the first stop bit ends.
  - Data sampled once each.
- Change tx_data to 8'h3C mid-frame of 8'hA5 → transmitted bits still match 8'hA5.
- Assert reset at cycle 14 of a frame → tx=1 in the same cycle (async), state IDLE, next acceptance yields a clean full frame.
- UART_TX_PARITY_EN defined, tx_data=8'h07 →
  - Parity bit=1 after the data bits.
  - Frame 44 cycles.
  - 8'h03 gives parity bit=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame parameters, line levels.
// Used by the transmitter now and by the future receiver.
package uart_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DEFAULT_DATA_BITS    = 8;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last count.
// clear restarts the bit period at count 0.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte intake, LSB-first frame of start, data, stop on tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    state_t               state, state_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_next;
    logic                 tx_next;
    logic                 tick;
    logic                 accept;

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = tx_valid && tx_ready;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .clear(accept),
        .tick (tick)
    );

`ifdef UART_TX_PARITY_EN
    logic parity;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity <= 1'b0;
        end else if (accept) begin
            parity <= ^tx_data;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            tx      <= LINE_IDLE;
        end else begin
            state   <= state_next;
            shift   <= shift_next;
            bit_cnt <= bit_cnt_next;
            tx      <= tx_next;
        end
    end

    always_comb begin
        state_next   = state;
        shift_next   = shift;
        bit_cnt_next = bit_cnt;
        tx_next      = LINE_IDLE;

        case (state)
            IDLE: begin
                if (accept) begin
                    shift_next   = tx_data;
                    bit_cnt_next = '0;
                    state_next   = START;
                end
            end
            START: begin
                if (tick) state_next = DATA;
            end
            DATA: begin
                if (tick) begin
                    shift_next   = shift >> 1;
                    bit_cnt_next = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) state_next = STOP;
            end
`endif
            STOP: begin
                if (tick) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // tx is registered, so drive the level belonging to the state being entered
        case (state_next)
            START:   tx_next = START_BIT;
            DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = parity;
`endif
            STOP:    tx_next = STOP_BIT;
            default: tx_next = LINE_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx with CLKS_PER_BIT=4, DATA_BITS=8.
// Covers UART_TX_PARITY_EN frames when the macro is defined.
module tb_uart_tx;

    localparam int CPB = 4;
    localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NBITS = DB + 2 + PAR;
    localparam int FRAME = NBITS * CPB;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_ready;
    logic       tx;
    logic       busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx      (tx),
        .busy    (busy)
    );

    // Expected line level for bit slot idx of a frame carrying d.
    function automatic logic exp_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DB) return d[idx-1];
        if (PAR == 1 && idx == DB + 1) return ^d;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (tx_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            step();
            tests++;
            if ({tx, tx_ready, busy} !== 3'b110)
                $display("FAIL reset_hold cycle %0d: {tx,ready,busy}=%b expected 110", c, {tx, tx_ready, busy});
        end
        reset = 1'b0;
        step();
        tests++;
        if ({tx, tx_ready, busy} !== 3'b110)
            $display("FAIL reset_release: {tx,ready,busy}=%b expected 110", {tx, tx_ready, busy});
    endtask

    task automatic test_single(input logic [7:0] d, input logic [7:0] late_data, input bit change);
        bit ok;
        wait_ready(ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL single_ready_timeout: ready=%b expected 1", tx_ready);
        end
        tx_data  = d;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        for (int c = 1; c <= FRAME; c++) begin
            if (change && c == 10) tx_data = late_data;
            tests++;
            if ({tx, tx_ready, busy} !== {exp_bit(d, (c - 1) / CPB), 2'b01}) begin
                fails++;
                $display("FAIL single_%h cycle %0d: {tx,ready,busy}=%b expected %b",
                         d, c, {tx, tx_ready, busy}, {exp_bit(d, (c - 1) / CPB), 2'b01});
            end
            step();
        end
        tests++;
        if ({tx, tx_ready, busy} !== 3'b110) begin
            fails++;
            $display("FAIL single_%h_end cycle %0d: {tx,ready,busy}=%b expected 110",
                     d, FRAME + 1, {tx, tx_ready, busy});
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        wait_ready(ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL b2b_ready_timeout: ready=%b expected 1", tx_ready);
        end
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        step();
        for (int c = 1; c <= FRAME; c++) begin
            if (c == 10) tx_data = 8'hFF;
            tests++;
            if ({tx, tx_ready, busy} !== {exp_bit(8'h00, (c - 1) / CPB), 2'b01}) begin
                fails++;
                $display("FAIL b2b_first cycle %0d: {tx,ready,busy}=%b expected %b",
                         c, {tx, tx_ready, busy}, {exp_bit(8'h00, (c - 1) / CPB), 2'b01});
            end
            step();
        end
        tests++;
        if ({tx, tx_ready, busy} !== 3'b110) begin
            fails++;
            $display("FAIL b2b_gap: {tx,ready,busy}=%b expected 110", {tx, tx_ready, busy});
        end
        step();
        tx_valid = 1'b0;
        for (int c = 1; c <= FRAME; c++) begin
            tests++;
            if ({tx, tx_ready, busy} !== {exp_bit(8'hFF, (c - 1) / CPB), 2'b01}) begin
                fails++;
                $display("FAIL b2b_second cycle %0d: {tx,ready,busy}=%b expected %b",
                         c, {tx, tx_ready, busy}, {exp_bit(8'hFF, (c - 1) / CPB), 2'b01});
            end
            step();
        end
        for (int c = 0; c < 6; c++) begin
            tests++;
            if ({tx, tx_ready, busy} !== 3'b110) begin
                fails++;
                $display("FAIL b2b_no_third idle %0d: {tx,ready,busy}=%b expected 110", c, {tx, tx_ready, busy});
            end
            step();
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        wait_ready(ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL midreset_ready_timeout: ready=%b expected 1", tx_ready);
        end
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        for (int c = 1; c < 14; c++) step();
        tests++;
        if ({tx, busy} !== 2'b01) begin
            fails++;
            $display("FAIL midreset_pre: {tx,busy}=%b expected 01", {tx, busy});
        end
        reset = 1'b1;
        #1;
        tests++;
        if ({tx, tx_ready, busy} !== 3'b110) begin
            fails++;
            $display("FAIL midreset_async: {tx,ready,busy}=%b expected 110", {tx, tx_ready, busy});
        end
        step();
        reset = 1'b0;
        step();
        tests++;
        if ({tx, tx_ready, busy} !== 3'b110) begin
            fails++;
            $display("FAIL midreset_after: {tx,ready,busy}=%b expected 110", {tx, tx_ready, busy});
        end
        test_single(8'hA5, 8'h00, 1'b0);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity(input logic [7:0] d, input logic par);
        bit ok;
        wait_ready(ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL parity_ready_timeout: ready=%b expected 1", tx_ready);
        end
        tx_data  = d;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        for (int c = 1; c <= 44; c++) begin
            if (c > 36 && c <= 40) begin
                tests++;
                if (tx !== par) begin
                    fails++;
                    $display("FAIL parity_bit_%h cycle %0d: tx=%b expected %b", d, c, tx, par);
                end
            end
            tests++;
            if (tx_ready !== 1'b0) begin
                fails++;
                $display("FAIL parity_len_%h cycle %0d: ready=%b expected 0", d, c, tx_ready);
            end
            step();
        end
        tests++;
        if ({tx, tx_ready, busy} !== 3'b110) begin
            fails++;
            $display("FAIL parity_end_%h: {tx,ready,busy}=%b expected 110", d, {tx, tx_ready, busy});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single(8'hA5, 8'h00, 1'b0);
        test_single(8'hA5, 8'h3C, 1'b1);
        test_back_to_back();
        test_reset_midframe();
`ifdef UART_TX_PARITY_EN
        test_parity(8'h07, 1'b1);
        test_parity(8'h03, 1'b0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
